// File: rtl/videomem_pkg.sv
// rtl/videomem_pkg.sv - shared response codes, FSM state types and default depth for the videomem frame buffer
package videomem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Default number of 32-bit words implemented behind the AXI window
  localparam int VIDEOMEM_DEPTH = 12288;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/videomem_bram.sv
// rtl/videomem_bram.sv - byte-writable frame-buffer RAM, read-first, registered read outputs
//
// Ports:
//   clk, rst              clock; synchronous active-high reset (clears output registers only)
//   wr_en/wr_be/wr_addr/wr_data   write side of the AXI port, per-byte enables
//   a_rd_en/a_rd_addr/a_rd_data   read side of the AXI port; output held when a_rd_en = 0
//   b_rd_addr/b_rd_data           read-only scanout port, read every cycle
// Addresses at or beyond DEPTH never write and read back as zero.
module videomem_bram
  import videomem_pkg::*;
#(
  parameter int DEPTH = VIDEOMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          a_rd_en,
  input  logic [AW-1:0] a_rd_addr,
  output logic [31:0]   a_rd_data,
  input  logic [AW-1:0] b_rd_addr,
  output logic [31:0]   b_rd_data
);

  logic [31:0] mem [DEPTH];

  // Storage has no reset so it maps onto block RAM and survives a soft reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i] && (32'(wr_addr) < DEPTH)) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_data <= '0;
      b_rd_data <= '0;
    end else begin
      if (a_rd_en) begin
        a_rd_data <= (32'(a_rd_addr) < DEPTH) ? mem[a_rd_addr] : '0;
      end
      b_rd_data <= (32'(b_rd_addr) < DEPTH) ? mem[b_rd_addr] : '0;
    end
  end

endmodule

// File: rtl/videomem_axil_slave.sv
// rtl/videomem_axil_slave.sv - AXI4-Lite slave frame buffer with an independent scanout read port
//
// Ports:
//   s00_axi_aclk, s00_axi_areset   clock; synchronous active-high reset
//   s00_axi_aw* / w* / b*          single-beat write channel (awprot ignored)
//   s00_axi_ar* / r*               single-beat read channel (arprot ignored)
//   pix_rd_addr, pix_rd_data       scanout word index in, word out one cycle later
// Word index is the byte address with bits [1:0] dropped; indices >= MEM_DEPTH give SLVERR.
module videomem_axil_slave
  import videomem_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int MEM_DEPTH          = VIDEOMEM_DEPTH
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [$clog2(MEM_DEPTH)-1:0]    pix_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pix_rd_data
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int RAM_AW = $clog2(MEM_DEPTH);

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [1:0]        bresp_q;
  logic              rd_err;

  logic              aw_free, w_free, ar_free;
  logic              aw_take, w_take, ar_take;
  logic              wr_fire, b_done;
  logic [IDX_W-1:0]  wr_idx, ar_idx;
  logic [31:0]       wr_data_m;
  logic [3:0]        wr_strb_m;
  logic              wr_in_range, ar_in_range;
  logic [31:0]       ram_rd_q;

  logic              unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign aw_free = (wr_state == W_IDLE) && !aw_full && !s00_axi_areset;
  assign w_free  = (wr_state == W_IDLE) && !w_full  && !s00_axi_areset;
  assign ar_free = (rd_state == R_IDLE) && !s00_axi_areset;
  assign aw_take = aw_free && s00_axi_awvalid;
  assign w_take  = w_free  && s00_axi_wvalid;
  assign ar_take = ar_free && s00_axi_arvalid;

  // A hold that fills this cycle is bypassed so the RAM write lands on the same edge.
  assign wr_idx      = aw_full ? aw_idx : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data_m   = w_full  ? w_data : s00_axi_wdata;
  assign wr_strb_m   = w_full  ? w_strb : s00_axi_wstrb;
  assign wr_in_range = 32'(wr_idx) < MEM_DEPTH;
  assign ar_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_in_range = 32'(ar_idx) < MEM_DEPTH;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next   = wr_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    wr_fire         = 1'b0;
    b_done          = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s00_axi_awready = aw_free;
        s00_axi_wready  = w_free;
        if ((aw_full || aw_take) && (w_full || w_take)) begin
          wr_fire       = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) begin
          b_done        = 1'b1;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next   = rd_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s00_axi_arready = ar_free;
        if (ar_take) rd_state_next = R_DATA;
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Holds stay full through W_RESP; that is what back-pressures a second AW/W.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= RESP_OKAY;
      rd_err  <= 1'b0;
    end else begin
      if (b_done) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_take) begin
          aw_full <= 1'b1;
          aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_take) begin
          w_full <= 1'b1;
          w_data <= s00_axi_wdata;
          w_strb <= s00_axi_wstrb;
        end
      end
      if (wr_fire) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (ar_take) rd_err  <= !ar_in_range;
    end
  end

  assign s00_axi_bresp = bresp_q;
  // The RAM output only moves on an AR handshake, so rdata/rresp are stable under back-pressure.
  assign s00_axi_rdata = rd_err ? '0 : ram_rd_q;
  assign s00_axi_rresp = rd_err ? RESP_SLVERR : RESP_OKAY;

  videomem_bram #(
    .DEPTH (MEM_DEPTH),
    .AW    (RAM_AW)
  ) u_bram (
    .clk       (s00_axi_aclk),
    .rst       (s00_axi_areset),
    .wr_en     (wr_fire && wr_in_range),
    .wr_be     (wr_strb_m),
    .wr_addr   (wr_idx[RAM_AW-1:0]),
    .wr_data   (wr_data_m),
    .a_rd_en   (ar_take),
    .a_rd_addr (ar_idx[RAM_AW-1:0]),
    .a_rd_data (ram_rd_q),
    .b_rd_addr (pix_rd_addr),
    .b_rd_data (pix_rd_data)
  );

endmodule

// File: tb/tb_videomem_axil_slave.sv
// tb/tb_videomem_axil_slave.sv - scoreboard bench for videomem_axil_slave
module tb_videomem_axil_slave;

  localparam int DEPTH = 12288;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [13:0] pix_rd_addr = '0;
  logic [31:0] pix_rd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [0:31];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  videomem_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .pix_rd_addr     (pix_rd_addr),
    .pix_rd_data     (pix_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within bound, expected one", name);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: word index = addr/4; in range iff index < DEPTH.
  function automatic logic [31:0] exp_rdata(input int idx);
    return (idx < DEPTH) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input int idx);
    return (idx < DEPTH) ? 2'b00 : 2'b10;
  endfunction

  task automatic drive_aw(input logic [15:0] a, input int dly);
    bit hs = 1'b0;
    repeat (dly) step();
    awaddr = a;
    awvalid = 1'b1;
    for (int n = 0; n < TMO && !hs; n++) begin
      @(negedge clk);
      hs = awready;
      step();
    end
    awvalid = 1'b0;
    if (!hs) timeout("aw_handshake");
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs = 1'b0;
    repeat (dly) step();
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int n = 0; n < TMO && !hs; n++) begin
      @(negedge clk);
      hs = wready;
      step();
    end
    wvalid = 1'b0;
    if (!hs) timeout("w_handshake");
  endtask

  task automatic drive_b(input int dly);
    bit hs = 1'b0;
    bready = 1'b0;
    repeat (dly) step();
    bready = 1'b1;
    for (int n = 0; n < TMO && !hs; n++) begin
      @(negedge clk);
      hs = bvalid;
      step();
    end
    bready = 1'b0;
    if (!hs) timeout("b_handshake");
  endtask

  task automatic drive_ar(input logic [15:0] a, input int dly);
    bit hs = 1'b0;
    repeat (dly) step();
    araddr = a;
    arvalid = 1'b1;
    for (int n = 0; n < TMO && !hs; n++) begin
      @(negedge clk);
      hs = arready;
      step();
    end
    arvalid = 1'b0;
    if (!hs) timeout("ar_handshake");
  endtask

  task automatic drive_r(input int dly);
    bit hs = 1'b0;
    rready = 1'b0;
    repeat (dly) step();
    rready = 1'b1;
    for (int n = 0; n < TMO && !hs; n++) begin
      @(negedge clk);
      hs = rvalid;
      step();
    end
    rready = 1'b0;
    if (!hs) timeout("r_handshake");
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
    int idx;
    idx = int'(a[15:2]);
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
    bq.push_back(exp_resp(idx));
    fork
      drive_aw(a, awd);
      drive_w(d, s, wd);
      drive_b(bd);
    join
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input int ard, input int rd);
    rq.push_back({er, ed});
    fork
      drive_ar(a, ard);
      drive_r(rd);
    join
  endtask

  // Monitor: pops the expected response whenever the DUT completes a B or R handshake.
  always @(negedge clk) begin
    logic [1:0]  eb;
    logic [33:0] er;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) timeout("b_unexpected_response");
      else begin
        eb = bq.pop_front();
        check("bresp", 32'(bresp), 32'(eb));
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) timeout("r_unexpected_response");
      else begin
        er = rq.pop_front();
        check("rdata", rdata, er[31:0]);
        check("rresp", 32'(rresp), 32'(er[33:32]));
      end
    end
  end

  function automatic int rand_idx();
    if ($urandom_range(0, 9) == 0) return DEPTH + int'($urandom_range(0, 4095));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    int first_b;
    int wi, ri, op;
    logic [31:0] old_pix;
    logic [31:0] ed;
    logic [1:0]  er;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);
    check("post_rst_bresp", bresp, 0);
    check("post_rst_rresp", rresp, 0);
    check("post_rst_rdata", rdata, 0);
    check("post_rst_pix", pix_rd_data, 0);
    step();

    // Give every word the bench may read a known value
    for (int i = 0; i < 32; i++) axi_write(16'(i * 4), $urandom, 4'hF, 0, 0, 0);

    // AW and W together: accepted at cycle 0, bvalid in cycle 1
    fork
      axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        check("same_cycle_aw_w_accept", {awready, wready}, 2'b11);
        @(negedge clk);
        check("same_cycle_bvalid_c1", bvalid, 1);
      end
    join
    step();
    fork
      axi_read(16'h0010, 32'hDEADBEEF, 2'b00, 0, 0);
      begin
        @(negedge clk);
        check("ar_accept", arready, 1);
        @(negedge clk);
        check("rvalid_c1", rvalid, 1);
      end
    join
    step();

    // W three cycles ahead of AW, partial strobes over all-ones
    axi_write(16'h0020, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    first_b = -1;
    fork
      axi_write(16'h0020, 32'h11223344, 4'b0101, 3, 0, 0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bvalid && first_b < 0) first_b = c;
        if (c >= 1 && c <= 3) check("w_hold_backpressure", wready, 0);
      end
    join
    check("w_early_first_b_cycle", first_b, 4);
    step();
    axi_read(16'h0020, 32'hFF22FF44, 2'b00, 0, 0);

    // Out-of-range index MEM_DEPTH
    ed = model[0];
    axi_write(16'hC000, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(16'hC000, 32'h0, 2'b10, 0, 0);
    axi_read(16'h0000, ed, 2'b00, 0, 0);

    // B and R back-pressured for 5 cycles
    fork
      axi_write(16'h0030, 32'h5A5AA5A5, 4'hF, 0, 0, 6);
      axi_read(16'h0010, 32'hDEADBEEF, 2'b00, 0, 6);
      begin
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_bvalid", bvalid, 1);
          check("stall_bresp", bresp, 0);
          check("stall_aw_w_ready", {awready, wready}, 2'b00);
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, 32'hDEADBEEF);
          check("stall_arready", arready, 0);
        end
      end
    join
    step();

    // Randomized traffic: write and read to distinct words, possibly concurrent
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 2));
      wi = rand_idx();
      ri = rand_idx();
      while (ri == wi) ri = rand_idx();
      ed = exp_rdata(ri);
      er = exp_resp(ri);
      fork
        if (op != 1) axi_write({wi[13:0], 2'($urandom_range(0, 3))}, $urandom,
                               4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        if (op != 0) axi_read({ri[13:0], 2'($urandom_range(0, 3))}, ed, er,
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      join
    end

    // Scanout port: one-cycle latency, zero out of range
    for (int i = 0; i < 8; i++) begin
      pix_rd_addr = 14'(i);
      step();
      @(negedge clk);
      check("pix_read", pix_rd_data, model[i]);
    end
    pix_rd_addr = 14'd12288;
    step();
    @(negedge clk);
    check("pix_out_of_range", pix_rd_data, 0);
    step();

    // Scanout read of a word written on the same edge returns old data
    pix_rd_addr = 14'd4;
    old_pix = model[4];
    fork
      axi_write(16'h0010, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("pix_read_first_old", pix_rd_data, old_pix);
        @(negedge clk);
        check("pix_read_first_new", pix_rd_data, 32'hCAFEF00D);
      end
    join
    step();

    // Reset while bvalid is pending drops the response, keeps RAM contents
    bready = 1'b0;
    awaddr = 16'h0040; awvalid = 1'b1;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid = 1'b0;
    model[16] = 32'h0BADF00D;
    @(negedge clk);
    check("pre_reset_bvalid", bvalid, 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_reset_bvalid", bvalid, 0);
    check("mid_reset_awready", awready, 0);
    check("mid_reset_pix", pix_rd_data, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_ready", {awready, wready, arready}, 3'b111);
    step();
    axi_read(16'h0010, 32'hCAFEF00D, 2'b00, 0, 0);
    axi_read(16'h0040, 32'h0BADF00D, 2'b00, 0, 0);
    axi_write(16'h0044, 32'h01020304, 4'hF, 0, 0, 0);

    repeat (2) step();
    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/videomem_axil_slave.md
# videomem_axil_slave

AXI4-Lite slave frame-buffer memory that receives the single-beat write/read traffic issued by the videomem pattern-generator master on its M00_AXI port. It stores 32-bit pixel words in an internal byte-writable RAM. A second, independent read-only pixel port lets the display scanout logic fetch words concurrently with AXI traffic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width.
- MEM_DEPTH, 12288, number of 32-bit words implemented; must be ≤ 2^(C_S_AXI_ADDR_WIDTH-2).

Ports (clock is s00_axi_aclk; reset is s00_axi_areset, synchronous, active-high):
- s00_axi_aclk  in  1  single clock; all logic on the rising edge.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  ADDR_WIDTH  read byte address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- pix_rd_addr  in  $clog2(MEM_DEPTH)  scanout word index.
- pix_rd_data  out  32  scanout word; 1-cycle latency.

## Operation
- Word index is addr[ADDR_WIDTH-1:2]. Bits [1:0] are ignored.
- Write path has states W_IDLE and W_RESP. AW and W are latched independently into aw_hold and w_hold.
  - awready = 1 in W_IDLE while aw_hold is empty; wready behaves the same way for w_hold.
- When both holds are full (or fill in the same cycle), the block writes the RAM, applying wstrb per byte, and moves to W_RESP with bvalid = 1.
  - An index ≥ MEM_DEPTH means no RAM write and bresp = SLVERR (2'b10); otherwise bresp = OKAY.
- In W_RESP, bvalid && bready clears both holds and returns to W_IDLE.
- Read path has states R_IDLE and R_DATA. arready = 1 only in R_IDLE.
  - On an AR handshake, the RAM is read and the path enters R_DATA with rvalid = 1.
  - An out-of-range index returns rdata = 0 and rresp = SLVERR.
  - rvalid && rready returns to R_IDLE.
- rdata and rresp hold stable while rvalid = 1 and rready = 0.
- Read and write paths are fully independent and may complete in the same cycle.
- RAM is read-first. A read (AXI or pixel port) of the word being written in the same cycle returns the old data.
- Pixel port: pix_rd_data <= mem[pix_rd_addr] every cycle, unconditionally. An out-of-range pix_rd_addr returns 0.
- Reset values: awready, wready, arready = 0 during reset and 1 on the first cycle after reset. bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0, pix_rd_data = 0.
  - Holds are cleared and both FSMs return to IDLE.
  - RAM contents are NOT cleared.
- Reset asserted mid-transaction abandons that transaction: a pending B or R is dropped and a half-latched AW/W is discarded.

## Timing
- AW and W in the same cycle (cycle 0, in W_IDLE): both accepted at cycle 0, RAM updated at the cycle-0 edge, bvalid = 1 in cycle 1.
- AW at cycle 0 and W at cycle k: bvalid = 1 in cycle k+1.
- With bready held high, the earliest next AW acceptance is the cycle after the B handshake, so throughput is 1 write per 2 cycles.
- AR accepted at cycle 0 gives rvalid = 1 in cycle 1. With rready held high, throughput is 1 read per 2 cycles.
- A second AW (or W) while its hold is full is back-pressured with ready = 0 until the B handshake.
- pix_rd_data reflects the pix_rd_addr sampled at the previous edge.

## Structure
- Package videomem_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - the default MEM_DEPTH constant.
- Sub-module videomem_bram holds the storage:
  - one read/write port with 4-bit byte enable, read-first;
  - one read-only port;
  - both with registered outputs.
- The top level contains only the AXI FSMs, holds and range checks.

## Test plan
- Write 0xDEADBEEF to 0x0010 with AW and W in the same cycle, then read 0x0010 -> bvalid in cycle 1 with OKAY; rdata = 0xDEADBEEF with OKAY.
- W presented 3 cycles before AW to 0x0020, wstrb = 4'b0101, data 0x11223344 over prior 0xFFFFFFFF -> single B with OKAY; readback 0xFF22FF44.
- Write to word index MEM_DEPTH (byte address 0xC000) -> bresp = SLVERR; a read of 0xC000 returns rdata = 0 with SLVERR; index 0 is unchanged.
- bready and rready held low for 5 cycles -> bvalid/rvalid stay 1 with stable data; awready and wready stay 0; arready stays 0 until the R handshake.
- pix_rd_addr = 4 while an AXI write of 0xCAFEF00D to 0x0010 (index 4) occurs in the same cycle -> pix_rd_data shows old data next cycle and 0xCAFEF00D the cycle after.
- Reset asserted while bvalid = 1 -> bvalid = 0 after the edge; data previously written to 0x0010 is still readable after reset.
